// File: rtl/systolic_ram_sequencer_if.sv
// rtl/systolic_ram_sequencer_if.sv - control, matrix RAM port and systolic array signals of the sequencer
interface systolic_ram_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    // run control
    logic              start;
    logic              busy;
    logic              done;
    logic              err;

    // single-port matrix RAM, one-cycle registered read
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do;

    // 2x2 systolic array operand feed
    logic              acc_clr;
    logic              feed_valid;
    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic [DATA_W-1:0] b_col0;
    logic [DATA_W-1:0] b_col1;

    // 2x2 systolic array result
    logic              res_valid;
    logic [DATA_W-1:0] c00;
    logic [DATA_W-1:0] c01;
    logic [DATA_W-1:0] c10;
    logic [DATA_W-1:0] c11;

    // sequencer side
    modport master (
        input  start, ram_do, res_valid, c00, c01, c10, c11,
        output busy, done, err,
        output ram_en, ram_we, ram_addr, ram_di,
        output acc_clr, feed_valid, a_row0, a_row1, b_col0, b_col1
    );

    // RAM / array / host side
    modport slave (
        output start, ram_do, res_valid, c00, c01, c10, c11,
        input  busy, done, err,
        input  ram_en, ram_we, ram_addr, ram_di,
        input  acc_clr, feed_valid, a_row0, a_row1, b_col0, b_col1
    );
endinterface

// File: rtl/systolic_ram_sequencer.sv
// rtl/systolic_ram_sequencer.sv - loads A/B from RAM, feeds the 2x2 systolic array skewed, writes C back; SEQ_TIMEOUT_EN adds a WAIT timeout
module systolic_ram_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 4,
    parameter int C_BASE  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    systolic_ram_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_FEED  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

`ifdef SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    // FSM position: state plus step index inside LOAD/FEED/WRITE
    logic [2:0]        r_state;
    logic [3:0]        r_step;
    logic [2:0]        w_nstate;
    logic [3:0]        w_nstep;

    // operands a[0..3] then b[0..3], in RAM issue order
    logic [DATA_W-1:0] r_op [0:7];
    logic [2:0]        w_cap_idx;

    // latched array results and their next value
    logic [DATA_W-1:0] r_c [0:3];
    logic [DATA_W-1:0] w_c [0:3];
    logic              w_res_take;

    // WAIT-state cycle counter, only consulted when the timeout is built in
    logic [TMO_W-1:0]  r_tmo;
    logic              w_timeout;

    // registered outputs and the values they take on the next edge
    logic              r_busy, r_done, r_err;
    logic              r_ram_en, r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_di;
    logic              r_acc_clr, r_feed_valid;
    logic [DATA_W-1:0] r_a_row0, r_a_row1, r_b_col0, r_b_col1;

    logic              w_busy, w_done, w_err;
    logic              w_ram_en, w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_di;
    logic              w_acc_clr, w_feed_valid;
    logic [DATA_W-1:0] w_a_row0, w_a_row1, w_b_col0, w_b_col1;

    assign w_res_take = (r_state == S_WAIT) && bus.res_valid;
    assign w_timeout  = TMO_EN && (r_state == S_WAIT) && !bus.res_valid &&
                        (r_tmo == TMO_W'(TIMEOUT - 1));
    // read issued in LOAD step k returns in step k+1
    assign w_cap_idx  = 3'(r_step - 4'd1);

    // result words as they will stand after this edge, so the first WRITE word is available immediately
    always_comb begin
        w_c[0] = w_res_take ? bus.c00 : r_c[0];
        w_c[1] = w_res_take ? bus.c01 : r_c[1];
        w_c[2] = w_res_take ? bus.c10 : r_c[2];
        w_c[3] = w_res_take ? bus.c11 : r_c[3];
    end

    // next state and step
    always_comb begin
        w_nstate = r_state;
        w_nstep  = r_step;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_nstate = S_LOAD;
                    w_nstep  = 4'd0;
                end
            end
            S_LOAD: begin
                if (r_step == 4'd8) begin
                    w_nstate = S_CLEAR;
                    w_nstep  = 4'd0;
                end else begin
                    w_nstep = r_step + 4'd1;
                end
            end
            S_CLEAR: begin
                w_nstate = S_FEED;
                w_nstep  = 4'd0;
            end
            S_FEED: begin
                if (r_step == 4'd2) begin
                    w_nstate = S_WAIT;
                    w_nstep  = 4'd0;
                end else begin
                    w_nstep = r_step + 4'd1;
                end
            end
            S_WAIT: begin
                if (bus.res_valid) begin
                    w_nstate = S_WRITE;
                    w_nstep  = 4'd0;
                end else if (w_timeout) begin
                    w_nstate = S_DONE;
                    w_nstep  = 4'd0;
                end
            end
            S_WRITE: begin
                if (r_step == 4'd3) begin
                    w_nstate = S_DONE;
                    w_nstep  = 4'd0;
                end else begin
                    w_nstep = r_step + 4'd1;
                end
            end
            S_DONE: begin
                w_nstate = S_IDLE;
                w_nstep  = 4'd0;
            end
            default: begin
                w_nstate = S_IDLE;
                w_nstep  = 4'd0;
            end
        endcase
    end

    // output values for the cycle being entered; registering them keeps every output glitch-free
    always_comb begin
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = '0;
        w_ram_di     = '0;
        w_acc_clr    = 1'b0;
        w_feed_valid = 1'b0;
        w_a_row0     = '0;
        w_a_row1     = '0;
        w_b_col0     = '0;
        w_b_col1     = '0;
        case (w_nstate)
            S_LOAD: begin
                w_busy = 1'b1;
                if (w_nstep < 4'd8) begin
                    w_ram_en = 1'b1;
                    // low two step bits are the offset inside A (steps 0-3) or B (steps 4-7)
                    if (w_nstep[2]) begin
                        w_ram_addr = ADDR_W'(B_BASE) + ADDR_W'(w_nstep[1:0]);
                    end else begin
                        w_ram_addr = ADDR_W'(A_BASE) + ADDR_W'(w_nstep[1:0]);
                    end
                end
            end
            S_CLEAR: begin
                w_busy    = 1'b1;
                w_acc_clr = 1'b1;
            end
            S_FEED: begin
                w_busy       = 1'b1;
                w_feed_valid = 1'b1;
                // row 1 / column 1 lag row 0 / column 0 by one cycle
                case (w_nstep[1:0])
                    2'd0: begin
                        w_a_row0 = r_op[0];
                        w_b_col0 = r_op[4];
                    end
                    2'd1: begin
                        w_a_row0 = r_op[1];
                        w_a_row1 = r_op[2];
                        w_b_col0 = r_op[6];
                        w_b_col1 = r_op[5];
                    end
                    default: begin
                        w_a_row1 = r_op[3];
                        w_b_col1 = r_op[7];
                    end
                endcase
            end
            S_WAIT: begin
                w_busy = 1'b1;
            end
            S_WRITE: begin
                w_busy     = 1'b1;
                w_ram_en   = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = ADDR_W'(C_BASE) + ADDR_W'(w_nstep[1:0]);
                w_ram_di   = w_c[w_nstep[1:0]];
            end
            S_DONE: begin
                w_done = 1'b1;
                // DONE is reached straight from WAIT only on a timeout
                w_err  = (r_state == S_WAIT);
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // state and registered outputs, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_step       <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_di     <= '0;
            r_acc_clr    <= 1'b0;
            r_feed_valid <= 1'b0;
            r_a_row0     <= '0;
            r_a_row1     <= '0;
            r_b_col0     <= '0;
            r_b_col1     <= '0;
        end else begin
            r_state      <= w_nstate;
            r_step       <= w_nstep;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_err        <= w_err;
            r_ram_en     <= w_ram_en;
            r_ram_we     <= w_ram_we;
            r_ram_addr   <= w_ram_addr;
            r_ram_di     <= w_ram_di;
            r_acc_clr    <= w_acc_clr;
            r_feed_valid <= w_feed_valid;
            r_a_row0     <= w_a_row0;
            r_a_row1     <= w_a_row1;
            r_b_col0     <= w_b_col0;
            r_b_col1     <= w_b_col1;
        end
    end

    // WAIT cycle counter, restarted on every entry to WAIT
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) begin
            r_tmo <= '0;
        end else if (r_tmo != TMO_W'(TIMEOUT - 1)) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // operand capture from the RAM read port during LOAD steps 1..8
    always_ff @(posedge clk) begin
        if ((r_state == S_LOAD) && (r_step != 4'd0)) begin
            r_op[w_cap_idx] <= bus.ram_do;
        end
    end

    // result latch; only a res_valid seen in WAIT updates it
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            r_c[i] <= w_c[i];
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.ram_en     = r_ram_en;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_di     = r_ram_di;
    assign bus.acc_clr    = r_acc_clr;
    assign bus.feed_valid = r_feed_valid;
    assign bus.a_row0     = r_a_row0;
    assign bus.a_row1     = r_a_row1;
    assign bus.b_col0     = r_b_col0;
    assign bus.b_col1     = r_b_col1;

endmodule

// File: tb/tb_systolic_ram_sequencer.sv
// tb/tb_systolic_ram_sequencer.sv - scoreboard bench for systolic_ram_sequencer with a one-cycle-latency RAM model
module tb_systolic_ram_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int BIG    = 1 << 30;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } acc_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    systolic_ram_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    systolic_ram_sequencer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .A_BASE (0),
        .B_BASE (4),
        .C_BASE (8),
        .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int a_init[4] = '{9, 1, 1, 9};
    int b_init[4] = '{8, 4, 1, 1};

    logic [DATA_W-1:0] mem [0:15];

    // RAM model: registered read, write on enable
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4; i++) begin
                mem[i]     <= DATA_W'(a_init[i]);
                mem[i + 4] <= DATA_W'(b_init[i]);
            end
            for (int i = 8; i < 16; i++) mem[i] <= '0;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
            else            bus.ram_do <= mem[bus.ram_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_rd, n_wr, n_done;

    acc_t exp_rd[$];
    acc_t exp_wr[$];
    acc_t exp_done[$];

    // reference run position
    int t0    = -1000;
    int m_end = -1;
    bit m_acc = 1'b0;

    // stimulus schedule (absolute cycles; -1 / empty ranges never match)
    int s_pulse, s_lo, s_hi, r_pulse, r_lo, r_hi, rst_at;
    int cv[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_sched();
        s_pulse = -1; s_lo = 1; s_hi = 0;
        r_pulse = -1; r_lo = 1; r_hi = 0;
        rst_at  = -1;
        n_rd = 0; n_wr = 0; n_done = 0;
    endtask

    function automatic int exp_feed(input int sel, input int rel, input bit live);
        if (!live) return 0;
        case (sel)
            0:       return (rel == 10) ? a_init[0] : (rel == 11) ? a_init[1] : 0;
            1:       return (rel == 11) ? a_init[2] : (rel == 12) ? a_init[3] : 0;
            2:       return (rel == 10) ? b_init[0] : (rel == 11) ? b_init[2] : 0;
            default: return (rel == 11) ? b_init[1] : (rel == 12) ? b_init[3] : 0;
        endcase
    endfunction

    // advance to cycle `last`: sample and check each cycle mid-period, then drive the next inputs
    task automatic sim(input int last);
        acc_t e;
        int   rel;
        bit   live, st, rv, rs;
        int   cur[4];
        while (cyc < last) begin
            @(negedge clk);
            cyc++;
            rel  = cyc - t0;
            live = (cyc >= t0) && (cyc < m_end);

            if (bus.ram_en && !bus.ram_we) begin
                n_rd++;
                chk("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", bus.ram_addr, e.addr);
                end
            end
            if (bus.ram_we) begin
                chk("we_needs_en", bus.ram_en, 1);
                n_wr++;
                chk("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", bus.ram_addr, e.addr);
                    chk("wr_data", bus.ram_di, e.data);
                end
            end
            if (bus.done) begin
                n_done++;
                chk("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_err", bus.err, e.data);
                end
            end else begin
                chk("err_without_done", bus.err, 0);
            end
            chk("busy", bus.busy, live);
            chk("acc_clr", bus.acc_clr, live && (rel == 9));
            chk("feed_valid", bus.feed_valid, live && (rel >= 10) && (rel <= 12));
            chk("a_row0", bus.a_row0, exp_feed(0, rel, live));
            chk("a_row1", bus.a_row1, exp_feed(1, rel, live));
            chk("b_col0", bus.b_col0, exp_feed(2, rel, live));
            chk("b_col1", bus.b_col1, exp_feed(3, rel, live));

            // inputs for this cycle and the reference model's reaction to them
            st = (cyc == s_pulse) || ((cyc >= s_lo) && (cyc <= s_hi));
            rv = (cyc == r_pulse) || ((cyc >= r_lo) && (cyc <= r_hi));
            rs = (cyc == rst_at);
            for (int i = 0; i < 4; i++) begin
                cur[i] = (cyc == r_pulse) ? cv[i] : int'($urandom_range(0, 65535));
            end

            if (rs) begin
                exp_rd.delete();
                exp_wr.delete();
                exp_done.delete();
                m_end = cyc;
            end else if (st && (cyc > m_end)) begin
                t0    = cyc + 1;
                m_end = BIG;
                m_acc = 1'b0;
                for (int i = 0; i < 8; i++) exp_rd.push_back('{cyc + 1 + i, i, 0});
            end else if (rv && live && !m_acc && (rel >= 13)) begin
                m_acc = 1'b1;
                for (int i = 0; i < 4; i++) exp_wr.push_back('{cyc + 1 + i, 8 + i, cur[i]});
                exp_done.push_back('{cyc + 5, 0, 0});
                m_end = cyc + 5;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (live && !m_acc && (rel == 76)) begin
                m_acc = 1'b1;
                exp_done.push_back('{cyc + 1, 0, 1});
                m_end = cyc + 1;
            end
`endif

            rst           = rs;
            bus.start     = st;
            bus.res_valid = rv;
            bus.c00       = DATA_W'(cur[0]);
            bus.c01       = DATA_W'(cur[1]);
            bus.c10       = DATA_W'(cur[2]);
            bus.c11       = DATA_W'(cur[3]);
        end
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_rd_pending"},   exp_rd.size(), 0);
        chk({tag, "_wr_pending"},   exp_wr.size(), 0);
        chk({tag, "_done_pending"}, exp_done.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b1; mem_init = 1'b1;
        bus.start = 1'b0; bus.res_valid = 1'b0;
        bus.c00 = '0; bus.c01 = '0; bus.c10 = '0; bus.c11 = '0;
        clear_sched();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_acc_clr", bus.acc_clr, 0);
        chk("rst_feed_valid", bus.feed_valid, 0);
        rst = 1'b0; mem_init = 1'b0;

        // nominal: start pulse, result at cycle 20
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; r_pulse = b + 20;
        cv = '{73, 37, 17, 13};
        sim(b + 30);
        chk("nom_reads", n_rd, 8);
        chk("nom_writes", n_wr, 4);
        chk("nom_dones", n_done, 1);
        chk_drained("nom");
        chk("nom_mem8", mem[8], 73);
        chk("nom_mem9", mem[9], 37);
        chk("nom_mem10", mem[10], 17);
        chk("nom_mem11", mem[11], 13);

        // start held high while busy
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; s_lo = b + 3; s_hi = b + 15; r_pulse = b + 20;
        cv = '{16'h1234, 16'hffff, 16'h0001, 16'h8000};
        sim(b + 40);
        chk("hold_reads", n_rd, 8);
        chk("hold_writes", n_wr, 4);
        chk("hold_dones", n_done, 1);
        chk_drained("hold");

        // reset in cycle 5
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; rst_at = b + 5; r_pulse = b + 20;
        cv = '{1, 2, 3, 4};
        sim(b + 30);
        chk("rst_reads", n_rd, 6);
        chk("rst_writes", n_wr, 0);
        chk("rst_dones", n_done, 0);
        chk_drained("rstmid");

        // early res_valid in FEED ignored, accepted at cycle 16 (minimum-latency side)
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; r_lo = b + 10; r_hi = b + 12; r_pulse = b + 16;
        cv = '{16'h00aa, 16'h0bb0, 16'hc00c, 16'hd00d};
        sim(b + 30);
        chk("early_writes", n_wr, 4);
        chk("early_dones", n_done, 1);
        chk_drained("early");

        // minimum run: res_valid in the first WAIT cycle
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; r_pulse = b + 13;
        cv = '{5, 6, 7, 8};
        sim(b + 25);
        chk("min_writes", n_wr, 4);
        chk("min_dones", n_done, 1);
        chk_drained("min");

        // res_valid never arrives
        clear_sched();
        b = cyc + 2; s_pulse = b - 1; rst_at = b + 90;
        sim(b + 95);
        chk("tmo_writes", n_wr, 0);
`ifdef SEQ_TIMEOUT_EN
        chk("tmo_dones", n_done, 1);
`else
        chk("tmo_dones", n_done, 0);
`endif
        chk_drained("tmo");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_ram_sequencer.md
# systolic_ram_sequencer

Initiator-side sequencer for the single-port matrix RAM in the 2x2 systolic datapath. It drives the RAM's `en`/`we`/`addr`/`di` port and consumes its registered `do` output with one-cycle read latency. On `start` it loads 2x2 matrices A and B, feeds them skewed into the 2x2 systolic array, and waits for the array's result. It then writes the four result words back into the same RAM.

## Interface
Parameters:
- `DATA_W`, 16: RAM word and array operand width.
- `ADDR_W`, 4: RAM address width.
- `A_BASE`, 0: address of A00. A is row-major: A00, A01, A10, A11.
- `B_BASE`, 4: address of B00. B is row-major.
- `C_BASE`, 8: address where C00, C01, C10, C11 are written.
- `TIMEOUT`, 64: WAIT-state cycle limit. Used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `busy`  out  1  high from LOAD through WRITE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  timeout flag, valid with `done`.
- `ram_en`, `ram_we`  out  1  RAM enable and write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_di`  out  DATA_W  RAM write data.
- `ram_do`  in  DATA_W  RAM read data; word addressed in cycle k is valid in cycle k+1.
- `acc_clr`  out  1  array accumulator clear.
- `feed_valid`  out  1  array operands valid.
- `a_row0`, `a_row1`, `b_col0`, `b_col1`  out  DATA_W  skewed array operands.
- `res_valid`  in  1  array result valid.
- `c00`, `c01`, `c10`, `c11`  in  DATA_W  array results.

## Operation
States: IDLE → LOAD → CLEAR → FEED → WAIT → WRITE → DONE → IDLE.

- **IDLE**
  - All outputs 0.
  - `start`=1 → LOAD next cycle; that cycle is run cycle 0.
- **LOAD**, cycles 0..8
  - Cycles 0–3: `ram_en`=1, `ram_we`=0, `ram_addr`=A_BASE+i.
  - Cycles 4–7: `ram_en`=1, `ram_we`=0, `ram_addr`=B_BASE+(i−4).
  - Cycle 8: `ram_en`=0.
  - In cycles 1..8, `ram_do` is captured into internal regs a[0..3], b[0..3] in issue order.
- **CLEAR**, cycle 9: `acc_clr`=1 for one cycle.
- **FEED**, cycles 10–12, `feed_valid`=1. Operand sequence per cycle:
  - `a_row0` = A00, A01, 0
  - `a_row1` = 0, A10, A11
  - `b_col0` = B00, B10, 0
  - `b_col1` = 0, B01, B11
- **WAIT**
  - Outputs idle; `res_valid` is sampled.
  - `res_valid`=1 in cycle W → c00..c11 latched, WRITE next cycle.
  - `res_valid` is ignored in every other state.
- **WRITE**, cycles W+1..W+4
  - `ram_en`=1, `ram_we`=1.
  - `ram_addr`=C_BASE+i, `ram_di`=c00, c01, c10, c11 in that order.
- **DONE**, cycle W+5: `done`=1, `busy`=0, then IDLE.

Boundary conditions:
- Address arithmetic is modulo 2^ADDR_W; BASE+i wraps silently.
- `start` while not in IDLE (including DONE) is ignored, with no queuing. If `start` is held high, a new run begins in the cycle after IDLE is re-entered.
- Reset at any point, including mid-WRITE: next cycle the state is IDLE and all outputs are 0. No further RAM accesses are issued; a partially written C region is left as is.
- `ram_we`=1 only in WRITE. `ram_en` is never high in IDLE, CLEAR, FEED, WAIT or DONE.

## Timing
- Reset value of every output: 0.
- All outputs are registered and change only on `clk` rising edges.
- `busy` is high in cycles 0..W+4.
- Minimum run: res_valid at cycle 13 gives `done` at cycle 18.
- Read-capture latency: exactly 1 cycle after issue.

## Configuration
`SEQ_TIMEOUT_EN`:
- **Defined:** a counter runs in WAIT. If `res_valid` has not been seen within TIMEOUT cycles (counting from the first WAIT cycle), the FSM goes straight to DONE with `err`=1 and `done`=1, skips WRITE, and issues no RAM writes.
- **Undefined:** WAIT waits indefinitely and `err` is tied to 0.

## Test plan
The bench RAM model has 1-cycle read latency and is preloaded with A=[9,1;1,9] at addresses 0–3 and B=[8,4;1,1] at addresses 4–7.
- **Nominal:** `start` pulse → reads of addresses 0..7 in cycles 0..7; `acc_clr` in cycle 9. Bench drives `res_valid` in cycle 20 with c=73,37,17,13 → writes to addresses 8..11 in cycles 21..24 with those values; `done` in cycle 25.
- **Skew:** nominal run → over cycles 10/11/12:
  - `a_row0` = 9/1/0, `a_row1` = 0/1/9
  - `b_col0` = 8/1/0, `b_col1` = 0/4/1
- **Start while busy:** `start` held high in cycles 3..15 → exactly one run: 8 reads, 4 writes, one `done`.
- **Reset mid-run:** `rst` in cycle 5 → cycle 6 has all outputs 0 and `busy`=0; no writes occur.
- **Early res_valid:** `res_valid` asserted in cycles 10–12 only, then again in cycle 16 → values are latched from cycle 16 only.
- **Timeout (macro defined, TIMEOUT=64):** `res_valid` never asserted → `done`=1 and `err`=1 in cycle 77; zero cycles with `ram_we` high.
